fb_write_arbiter: RTL

- Owns frame-buffer port A (write side) and shares it between two requesters: microprocessor single-pixel writes and a hardware rectangle-fill engine (clear screen, fill box).
- Sits between the bus-decode logic and the 160x120 1-bit frame buffer.
- Drives FB address {Y[6:0],X[7:0]}, data and write enable.
- The VGA read port B is untouched.

---
 rtl/vga_fb_pkg.sv | 24 ++
 rtl/fill_raster_gen.sv | 53 +++++
 rtl/fb_write_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the frame-buffer write path.
// Widths, default screen size, arbiter state encoding, {Y,X} packing.
package vga_fb_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int ADDR_W   = 15;
    localparam int HOR_DEF  = 160;
    localparam int VERT_DEF = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [Y_W-1:0] y,
        input logic [X_W-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/fill_raster_gen.sv
// Raster-order x/y walker for the rectangle-fill engine.
// load: latch bounds, x=x0, y=y0; step: advance one pixel; last: at (x1,y1).
module fill_raster_gen
    import vga_fb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [X_W-1:0] x0_q;
    logic [X_W-1:0] x1_q;
    logic [Y_W-1:0] y1_q;

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == x1_q) && (y_q == y1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else if (load) begin
            x_q  <= x0;
            y_q  <= y0;
            x0_q <= x0;
            x1_q <= x1;
            y1_q <= y1;
        end else if (step && !last) begin
            // Hold on the last pixel so y never runs past the box.
            if (x_q == x1_q) begin
                x_q <= x0_q;
                y_q <= y_q + Y_W'(1);
            end else begin
                x_q <= x_q + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer port A write arbiter: CPU pixel writes vs. rectangle fill.
// CPU_* handshake, FILL_* control/status, FB_* registered write port.
module fb_write_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned HOR_RES  = HOR_DEF,
    parameter int unsigned VERT_RES = VERT_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CPU_REQ,
    input  logic [X_W-1:0]    CPU_X,
    input  logic [Y_W-1:0]    CPU_Y,
    input  logic              CPU_DATA,
    output logic              CPU_ACK,
    input  logic              FILL_START,
    input  logic [X_W-1:0]    FILL_X0,
    input  logic [Y_W-1:0]    FILL_Y0,
    input  logic [X_W-1:0]    FILL_X1,
    input  logic [Y_W-1:0]    FILL_Y1,
    input  logic              FILL_VAL,
    input  logic              FILL_ABORT,
    output logic              FILL_BUSY,
    output logic              FILL_DONE,
    output logic              FILL_ERR,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic              FB_DATA,
    output logic              FB_WE
);

    localparam logic [X_W:0] HOR_LIM  = (X_W+1)'(HOR_RES);
    localparam logic [Y_W:0] VERT_LIM = (Y_W+1)'(VERT_RES);

    fill_state_t    state;
    logic           fill_val_q;
    logic           cpu_grant;
    logic           rect_ok;
    logic           fill_step;
    logic           rast_load;
    logic [X_W-1:0] rx;
    logic [Y_W-1:0] ry;
    logic           rlast;

    // ACK mask keeps a still-held REQ from being granted twice.
    always_comb begin
        cpu_grant = CPU_REQ && !CPU_ACK;
        rect_ok   = (FILL_X0 <= FILL_X1)
                 && (FILL_Y0 <= FILL_Y1)
                 && ({1'b0, FILL_X1} < HOR_LIM)
                 && ({1'b0, FILL_Y1} < VERT_LIM);
        fill_step = (state == ST_FILL) && !cpu_grant;
        rast_load = (state == ST_IDLE) && FILL_START && rect_ok;
    end

    fill_raster_gen u_raster (
        .clk   (CLK),
        .rst_n (RESET_N),
        .load  (rast_load),
        .step  (fill_step),
        .x0    (FILL_X0),
        .y0    (FILL_Y0),
        .x1    (FILL_X1),
        .y1    (FILL_Y1),
        .x     (rx),
        .y     (ry),
        .last  (rlast)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            fill_val_q <= 1'b0;
            CPU_ACK    <= 1'b0;
            FILL_BUSY  <= 1'b0;
            FILL_DONE  <= 1'b0;
            FILL_ERR   <= 1'b0;
            FB_ADDR    <= '0;
            FB_DATA    <= 1'b0;
            FB_WE      <= 1'b0;
        end else begin
            FB_WE     <= 1'b0;
            CPU_ACK   <= 1'b0;
            FILL_DONE <= 1'b0;
            FILL_ERR  <= 1'b0;

            if (cpu_grant) begin
                FB_WE   <= 1'b1;
                FB_ADDR <= pack_addr(CPU_Y, CPU_X);
                FB_DATA <= CPU_DATA;
                CPU_ACK <= 1'b1;
            end else if (fill_step) begin
                FB_WE   <= 1'b1;
                FB_ADDR <= pack_addr(ry, rx);
                FB_DATA <= fill_val_q;
            end

            unique case (state)
                ST_IDLE: begin
                    if (FILL_START) begin
                        if (rect_ok) begin
                            fill_val_q <= FILL_VAL;
                            state      <= ST_FILL;
                            FILL_BUSY  <= 1'b1;
                        end else begin
                            FILL_ERR <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    // A write arbitrated in the abort cycle still goes out.
                    if (FILL_ABORT) begin
                        state     <= ST_IDLE;
                        FILL_BUSY <= 1'b0;
                    end else if (fill_step && rlast) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    FILL_DONE <= 1'b1;
                    FILL_BUSY <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    FILL_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
